// File: rtl/piece_queue_if.sv
// Bag-fetch handshake with the randombag generator plus the game-side pop/preview bus.
interface piece_queue_if #(
  parameter int unsigned PREVIEW = 3
);
  logic                   newbag;
  logic                   bag_ready;
  logic [20:0]            bag_pieces;
  logic                   piece_req;
  logic                   piece_valid;
  logic [2:0]             piece;
  logic [3*PREVIEW-1:0]   preview;
  logic                   bag_err;

  modport master (
    output bag_ready, bag_pieces, piece_req,
    input  newbag, piece_valid, piece, preview, bag_err
  );

  modport slave (
    input  bag_ready, bag_pieces, piece_req,
    output newbag, piece_valid, piece, preview, bag_err
  );
endinterface

// File: rtl/piece_queue.sv
// Two-bag piece FIFO: fetches 7-piece bags from randombag, dispenses one piece per request
// and exposes a registered look-ahead window behind the head piece.
module piece_queue #(
  parameter int unsigned PREVIEW = 3
) (
  input  logic          clk,
  input  logic          nreset,
  piece_queue_if.slave  bus
);
  localparam int unsigned DEPTH = 14;
  localparam int unsigned BAG   = 7;
  localparam int unsigned CW    = 4;
  localparam int unsigned PW    = 3;
  localparam logic [PW-1:0] EMPTY = 3'd7;

  typedef enum logic {REQ, WAIT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   count, count_n, count_base;
  logic [PW-1:0]   mem   [DEPTH];
  logic [PW-1:0]   mem_n [DEPTH];
  logic [PW-1:0]   bag   [BAG];
  logic [2:0]      off;
  logic [7:0]      seen;
  logic            ready_q, newbag_q, valid_q, err_q;
  logic            newbag_c, load_c, pop_c, bad_c;

  for (genvar g = 0; g < BAG; g++) begin : g_unpack
    assign bag[g] = bus.bag_pieces[PW*g +: PW];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= REQ;
    else         state <= state_n;
  end

  // Fetch control: request when one bag of room is free, load on a fresh ready edge.
  always_comb begin
    state_n  = state;
    newbag_c = 1'b0;
    load_c   = 1'b0;
    case (state)
      REQ: begin
        if (count <= CW'(BAG)) begin
          newbag_c = 1'b1;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (bus.bag_ready && !ready_q) begin
          load_c  = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

  assign pop_c = bus.piece_req && valid_q;

  // Pop shifts toward the head first, so a same-cycle load lands behind the surviving entries.
  always_comb begin
    mem_n      = mem;
    off        = 3'd0;
    count_base = pop_c ? count - CW'(1) : count;
    if (pop_c) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
      mem_n[DEPTH-1] = EMPTY;
    end
    if (load_c) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i >= int'(count_base) && i < int'(count_base) + int'(BAG)) begin
          off      = 3'(i - int'(count_base));
          mem_n[i] = bag[off];
        end
      end
    end
    count_n = load_c ? count_base + CW'(BAG) : count_base;
  end

  // A valid bag is a permutation of 0..6: no code 7 and no repeats.
  always_comb begin
    seen  = 8'd0;
    bad_c = 1'b0;
    for (int j = 0; j < BAG; j++) begin
      if (bag[j] == EMPTY || seen[bag[j]]) bad_c = 1'b1;
      seen[bag[j]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count    <= '0;
      ready_q  <= 1'b0;
      newbag_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      mem      <= '{default: EMPTY};
    end else begin
      count    <= count_n;
      ready_q  <= bus.bag_ready;
      newbag_q <= newbag_c;
      valid_q  <= (count_n != '0);
      mem      <= mem_n;
      if (load_c && bad_c) err_q <= 1'b1;
    end
  end

  assign bus.newbag      = newbag_q;
  assign bus.piece_valid = valid_q;
  assign bus.piece       = mem[0];
  assign bus.bag_err     = err_q;

  for (genvar k = 0; k < PREVIEW; k++) begin : g_preview
    assign bus.preview[PW*k +: PW] = mem[k+1];
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!nreset) count <= CW'(DEPTH));

endmodule

// File: tb/tb_piece_queue.sv
// Directed vector table plus reset/soak sequences for piece_queue at PREVIEW = 1, 3 and 7.
module tb_piece_queue;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        bag_ready = 1'b0;
  logic [20:0] bag_pieces = '0;
  logic        piece_req = 1'b0;
  int          errors = 0;
  int          checks = 0;

  localparam logic [20:0] BAG_A = 21'o6543210;
  localparam logic [20:0] BAG_B = 21'o0123456;
  localparam logic [20:0] BAG_C = 21'o0531642;
  localparam logic [20:0] BAG_D = 21'o4162503;
  localparam logic [20:0] BAG_E = 21'o0012345;
  localparam int SOAK_BAGS = 300;

  always #5 clk = ~clk;

  piece_queue_if #(.PREVIEW(3)) bus3 ();
  piece_queue_if #(.PREVIEW(1)) bus1 ();
  piece_queue_if #(.PREVIEW(7)) bus7 ();

  assign bus3.bag_ready = bag_ready;  assign bus3.bag_pieces = bag_pieces;  assign bus3.piece_req = piece_req;
  assign bus1.bag_ready = bag_ready;  assign bus1.bag_pieces = bag_pieces;  assign bus1.piece_req = piece_req;
  assign bus7.bag_ready = bag_ready;  assign bus7.bag_pieces = bag_pieces;  assign bus7.piece_req = piece_req;

  piece_queue #(.PREVIEW(3)) dut3 (.clk(clk), .nreset(nreset), .bus(bus3));
  piece_queue #(.PREVIEW(1)) dut1 (.clk(clk), .nreset(nreset), .bus(bus1));
  piece_queue #(.PREVIEW(7)) dut7 (.clk(clk), .nreset(nreset), .bus(bus7));

  typedef struct {
    logic        rdy;
    logic [20:0] bag;
    logic        req;
    logic        nb;
    logic        vld;
    logic [2:0]  pc;
    logic [8:0]  pv;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_v(input logic rdy, input logic [20:0] bag, input logic req, input logic nb,
                       input logic vld, input logic [2:0] pc, input logic [8:0] pv, input logic err);
    vec_t v;
    v.rdy = rdy; v.bag = bag; v.req = req; v.nb = nb; v.vld = vld; v.pc = pc; v.pv = pv; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic rdy, input logic [20:0] bag, input logic req);
    @(negedge clk);
    bag_ready = rdy; bag_pieces = bag; piece_req = req;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int idx, input logic nb, input logic vld,
                          input logic [2:0] pc, input logic [8:0] pv, input logic err);
    chk({tag, "_newbag"}, idx, 32'(bus3.newbag), 32'(nb));
    chk({tag, "_valid"},  idx, 32'(bus3.piece_valid), 32'(vld));
    chk({tag, "_piece"},  idx, 32'(bus3.piece), 32'(pc));
    chk({tag, "_preview"}, idx, 32'(bus3.preview), 32'(pv));
    chk({tag, "_err"},    idx, 32'(bus3.bag_err), 32'(err));
  endtask

  initial begin
    logic [2:0]  sb[$];
    logic [20:0] epv, bp;
    int          p[7];
    int          pend, loaded, cyc, nb_seen, t, j;
    logic        rise;

    // Startup fetch and second bag (expected preview is {slot2,slot1,slot0}).
    add_v(0, '0,    0, 1, 0, 3'd7, 9'o777, 0);
    add_v(0, '0,    0, 0, 0, 3'd7, 9'o777, 0);
    add_v(0, '0,    0, 0, 0, 3'd7, 9'o777, 0);
    add_v(0, '0,    0, 0, 0, 3'd7, 9'o777, 0);
    add_v(1, BAG_A, 0, 0, 1, 3'd0, 9'o321, 0);
    add_v(1, BAG_A, 0, 1, 1, 3'd0, 9'o321, 0);
    add_v(0, BAG_A, 0, 0, 1, 3'd0, 9'o321, 0);
    add_v(0, BAG_A, 0, 0, 1, 3'd0, 9'o321, 0);
    add_v(0, BAG_A, 0, 0, 1, 3'd0, 9'o321, 0);
    add_v(1, BAG_B, 0, 0, 1, 3'd0, 9'o321, 0);
    add_v(1, BAG_B, 0, 0, 1, 3'd0, 9'o321, 0);
    add_v(1, BAG_B, 0, 0, 1, 3'd0, 9'o321, 0);
    // Fourteen back-to-back pops across the bag boundary.
    add_v(1, BAG_B, 1, 0, 1, 3'd1, 9'o432, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd2, 9'o543, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd3, 9'o654, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd4, 9'o665, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd5, 9'o566, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd6, 9'o456, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd6, 9'o345, 0);
    add_v(1, BAG_B, 1, 1, 1, 3'd5, 9'o234, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd4, 9'o123, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd3, 9'o012, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd2, 9'o701, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd1, 9'o770, 0);
    add_v(1, BAG_B, 1, 0, 1, 3'd0, 9'o777, 0);
    add_v(1, BAG_B, 1, 0, 0, 3'd7, 9'o777, 0);
    add_v(1, BAG_B, 1, 0, 0, 3'd7, 9'o777, 0);
    // Load from empty, drain to one, then pop in the load cycle.
    add_v(0, BAG_B, 0, 0, 0, 3'd7, 9'o777, 0);
    add_v(1, BAG_C, 0, 0, 1, 3'd2, 9'o164, 0);
    add_v(1, BAG_C, 1, 1, 1, 3'd4, 9'o316, 0);
    add_v(0, BAG_C, 1, 0, 1, 3'd6, 9'o531, 0);
    add_v(0, BAG_C, 1, 0, 1, 3'd1, 9'o053, 0);
    add_v(0, BAG_C, 1, 0, 1, 3'd3, 9'o705, 0);
    add_v(0, BAG_C, 1, 0, 1, 3'd5, 9'o770, 0);
    add_v(0, BAG_C, 1, 0, 1, 3'd0, 9'o777, 0);
    add_v(1, BAG_D, 1, 0, 1, 3'd3, 9'o250, 0);
    add_v(1, BAG_D, 0, 1, 1, 3'd3, 9'o250, 0);
    // Duplicate-code bag: flagged, still dispensed verbatim.
    add_v(0, BAG_D, 0, 0, 1, 3'd3, 9'o250, 0);
    add_v(1, BAG_E, 0, 0, 1, 3'd3, 9'o250, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd0, 9'o625, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd5, 9'o162, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd2, 9'o416, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd6, 9'o541, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd1, 9'o454, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd4, 9'o345, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd5, 9'o234, 1);
    add_v(1, BAG_E, 1, 1, 1, 3'd4, 9'o123, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd3, 9'o012, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd2, 9'o001, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd1, 9'o700, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd0, 9'o770, 1);
    add_v(1, BAG_E, 1, 0, 1, 3'd0, 9'o777, 1);
    add_v(1, BAG_E, 1, 0, 0, 3'd7, 9'o777, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 3'd7, 9'o777, 0);
    @(posedge clk);
    #2 nreset = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].rdy, vecs[i].bag, vecs[i].req);
      chk_outs("vec", i, vecs[i].nb, vecs[i].vld, vecs[i].pc, vecs[i].pv, vecs[i].err);
    end

    // Asynchronous reset while waiting on a bag, with a stale ready held high.
    apply(0, BAG_A, 0);
    chk_outs("r6pre", 0, 0, 0, 3'd7, 9'o777, 1);
    apply(1, BAG_A, 0);
    chk_outs("r6pre", 1, 0, 1, 3'd0, 9'o321, 1);
    apply(1, BAG_A, 0);
    chk_outs("r6pre", 2, 1, 1, 3'd0, 9'o321, 1);
    @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 0, 3'd7, 9'o777, 0);
    @(posedge clk);
    #1;
    chk_outs("async_rst", 1, 0, 0, 3'd7, 9'o777, 0);
    @(posedge clk);
    #2 nreset = 1'b1;
    nb_seen = 0;
    for (int i = 0; i < 6; i++) begin
      apply(1, BAG_B, 0);
      if (bus3.newbag) nb_seen++;
      chk("stale_newbag", i, 32'(bus3.newbag), 32'(i == 0));
      chk("stale_valid", i, 32'(bus3.piece_valid), 32'd0);
    end
    chk("stale_newbag_count", 0, 32'(nb_seen), 32'd1);
    apply(0, BAG_B, 0);
    chk_outs("reload", 0, 0, 0, 3'd7, 9'o777, 0);
    apply(1, BAG_B, 0);
    chk_outs("reload", 1, 0, 1, 3'd6, 9'o345, 0);

    // Randomised soak against a scoreboard, all preview depths in lockstep.
    @(negedge clk);
    nreset = 1'b0; bag_ready = 1'b0; piece_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    pend = -1; loaded = 0; cyc = 0;
    while (loaded < SOAK_BAGS && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      epv = '0;
      for (int k = 6; k >= 0; k--) epv = {epv[17:0], (k + 1 < sb.size()) ? sb[k+1] : 3'd7};
      chk("soak_valid",  cyc, 32'(bus3.piece_valid), 32'(sb.size() != 0));
      chk("soak_piece3", cyc, 32'(bus3.piece), 32'((sb.size() != 0) ? sb[0] : 3'd7));
      chk("soak_piece1", cyc, 32'(bus1.piece), 32'((sb.size() != 0) ? sb[0] : 3'd7));
      chk("soak_piece7", cyc, 32'(bus7.piece), 32'((sb.size() != 0) ? sb[0] : 3'd7));
      chk("soak_prev1",  cyc, 32'(bus1.preview), 32'(epv[2:0]));
      chk("soak_prev3",  cyc, 32'(bus3.preview), 32'(epv[8:0]));
      chk("soak_prev7",  cyc, 32'(bus7.preview), 32'(epv));
      chk("soak_err",    cyc, 32'({bus1.bag_err, bus3.bag_err, bus7.bag_err}), 32'd0);
      rise = 1'b0;
      if (bus3.newbag) begin
        bag_ready = 1'b0;
        pend = int'($urandom_range(1, 5));
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          for (int i = 0; i < 7; i++) p[i] = i;
          for (int i = 6; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = p[i]; p[i] = p[j]; p[j] = t;
          end
          bp = '0;
          for (int i = 6; i >= 0; i--) bp = {bp[17:0], 3'(p[i])};
          bag_pieces = bp;
          bag_ready = 1'b1;
          rise = 1'b1;
          pend = -1;
        end
      end
      piece_req = ($urandom_range(0, 3) != 0);
      if (piece_req && sb.size() != 0) void'(sb.pop_front());
      if (rise) begin
        for (int i = 0; i < 7; i++) sb.push_back(3'(p[i]));
        loaded++;
      end
    end
    chk("soak_bags", 0, 32'(loaded), 32'(SOAK_BAGS));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
